sram_arbiter: RTL

Parametrised multi-channel arbiter between N bus masters (CPU, video fetch, DMA, disk buffer) and the single shared asynchronous SRAM behind the `va`/`vd` bus. It generalises the fixed CPU/video split of the current ULA memory path to any channel count, any address or data width, and a programmable access length. Each channel gets a request/grant/ack handshake. The block drives the SRAM address, data and active-low strobes from registers.

---
 rtl/sram_arbiter_if.sv | 33 +++
 rtl/sram_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: request/grant/ack handshake for the bus masters plus the
// shared asynchronous SRAM pins, grouped so the arbiter takes one bus port.
// The slave modport is the arbiter's view; the master modport is the view of
// the requesters together with the SRAM device.
interface sram_arbiter_if #(
    parameter int CHANNELS = 3,
    parameter int AW       = 19,
    parameter int DW       = 8
);
    logic [CHANNELS-1:0]    req;
    logic [CHANNELS-1:0]    we;
    logic [CHANNELS*AW-1:0] addr;
    logic [CHANNELS*DW-1:0] wdata;
    logic [CHANNELS-1:0]    gnt;
    logic [CHANNELS-1:0]    ack;
    logic [DW-1:0]          rdata;
    logic [AW-1:0]          sram_a;
    logic [DW-1:0]          sram_d_o;
    logic                   sram_d_oe;
    logic [DW-1:0]          sram_d_i;
    logic                   n_sram_rd;
    logic                   n_sram_wr;

    modport slave (
        input  req, we, addr, wdata, sram_d_i,
        output gnt, ack, rdata, sram_a, sram_d_o, sram_d_oe, n_sram_rd, n_sram_wr
    );

    modport master (
        output req, we, addr, wdata, sram_d_i,
        input  gnt, ack, rdata, sram_a, sram_d_o, sram_d_oe, n_sram_rd, n_sram_wr
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: arbitrates CHANNELS bus masters onto one asynchronous SRAM.
// Each access: IDLE (sample requests, register address/data, drop strobe)
// -> ACCESS for ACC_CYCLES clocks -> RECOVER (writes only, data hold) -> IDLE.
// All SRAM pins come straight from registers.
// Build option: SRAM_ARB_ROUNDROBIN_EN selects round-robin arbitration
// starting after the last winner; without it the lowest requesting index wins.
module sram_arbiter #(
    parameter int CHANNELS   = 3,
    parameter int AW         = 19,
    parameter int DW         = 8,
    parameter int ACC_CYCLES = 2
) (
    input  logic          clk28,
    input  logic          rst,
    sram_arbiter_if.slave bus
);
    localparam int PW = $clog2(CHANNELS);
    localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

`ifdef SRAM_ARB_ROUNDROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RECOVER
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [CHANNELS-1:0]   r_sel_oh;
    logic [PW-1:0]         r_last;
    logic                  r_we;
    logic [CHANNELS-1:0]   r_gnt;
    logic [CHANNELS-1:0]   r_ack;
    logic [DW-1:0]         r_rdata;
    logic [AW-1:0]         r_sram_a;
    logic [DW-1:0]         r_sram_d_o;
    logic                  r_sram_d_oe;
    logic                  r_n_sram_rd;
    logic                  r_n_sram_wr;

    state_t                w_state_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [CHANNELS-1:0]   w_sel_oh_nxt;
    logic [PW-1:0]         w_last_nxt;
    logic                  w_we_nxt;
    logic [CHANNELS-1:0]   w_gnt_nxt;
    logic [CHANNELS-1:0]   w_ack_nxt;
    logic [DW-1:0]         w_rdata_nxt;
    logic [AW-1:0]         w_sram_a_nxt;
    logic [DW-1:0]         w_sram_d_o_nxt;
    logic                  w_sram_d_oe_nxt;
    logic                  w_n_sram_rd_nxt;
    logic                  w_n_sram_wr_nxt;

    int unsigned           w_start;
    logic [PW-1:0]         w_idx;
    logic                  w_found;
    logic [PW-1:0]         w_pick;
    logic [CHANNELS-1:0]   w_pick_oh;
    logic                  w_pick_we;
    logic [AW-1:0]         w_pick_addr;
    logic [DW-1:0]         w_pick_wdata;

    // Winner scan: circular from last+1 (round-robin) or from index 0 (fixed).
    always_comb begin
        w_start = RR_EN ? (32'(r_last) + 32'd1) : 32'd0;
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            w_idx = PW'((w_start + k) % CHANNELS);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Route the winning channel's direction, address and write data.
    always_comb begin
        w_pick_oh    = '0;
        w_pick_we    = 1'b0;
        w_pick_addr  = '0;
        w_pick_wdata = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (PW'(k) == w_pick) begin
                w_pick_oh[k] = 1'b1;
                w_pick_we    = bus.we[k];
                w_pick_addr  = bus.addr[k*AW +: AW];
                w_pick_wdata = bus.wdata[k*DW +: DW];
            end
        end
    end

    // Next-state and next-output logic; gnt/ack default to zero so they pulse.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_sel_oh_nxt    = r_sel_oh;
        w_last_nxt      = r_last;
        w_we_nxt        = r_we;
        w_gnt_nxt       = '0;
        w_ack_nxt       = '0;
        w_rdata_nxt     = r_rdata;
        w_sram_a_nxt    = r_sram_a;
        w_sram_d_o_nxt  = r_sram_d_o;
        w_sram_d_oe_nxt = r_sram_d_oe;
        w_n_sram_rd_nxt = r_n_sram_rd;
        w_n_sram_wr_nxt = r_n_sram_wr;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = S_ACCESS;
                    w_cnt_nxt       = CW'(ACC_CYCLES - 1);
                    w_sel_oh_nxt    = w_pick_oh;
                    w_last_nxt      = w_pick;
                    w_we_nxt        = w_pick_we;
                    w_gnt_nxt       = w_pick_oh;
                    w_sram_a_nxt    = w_pick_addr;
                    w_sram_d_o_nxt  = w_pick_wdata;
                    w_sram_d_oe_nxt = w_pick_we;
                    w_n_sram_wr_nxt = !w_pick_we;
                    w_n_sram_rd_nxt = w_pick_we;
                end
            end
            S_ACCESS: begin
                if (r_cnt == '0) begin
                    w_n_sram_rd_nxt = 1'b1;
                    w_n_sram_wr_nxt = 1'b1;
                    w_ack_nxt       = r_sel_oh;
                    if (r_we) begin
                        w_state_nxt = S_RECOVER;
                    end else begin
                        w_rdata_nxt = bus.sram_d_i;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_RECOVER: begin
                w_sram_d_oe_nxt = 1'b0;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset forces strobes high immediately.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sel_oh    <= '0;
            r_last      <= PW'(CHANNELS - 1);
            r_we        <= 1'b0;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_sram_a    <= '0;
            r_sram_d_o  <= '0;
            r_sram_d_oe <= 1'b0;
            r_n_sram_rd <= 1'b1;
            r_n_sram_wr <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sel_oh    <= w_sel_oh_nxt;
            r_last      <= w_last_nxt;
            r_we        <= w_we_nxt;
            r_gnt       <= w_gnt_nxt;
            r_ack       <= w_ack_nxt;
            r_rdata     <= w_rdata_nxt;
            r_sram_a    <= w_sram_a_nxt;
            r_sram_d_o  <= w_sram_d_o_nxt;
            r_sram_d_oe <= w_sram_d_oe_nxt;
            r_n_sram_rd <= w_n_sram_rd_nxt;
            r_n_sram_wr <= w_n_sram_wr_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.ack       = r_ack;
    assign bus.rdata     = r_rdata;
    assign bus.sram_a    = r_sram_a;
    assign bus.sram_d_o  = r_sram_d_o;
    assign bus.sram_d_oe = r_sram_d_oe;
    assign bus.n_sram_rd = r_n_sram_rd;
    assign bus.n_sram_wr = r_n_sram_wr;
endmodule
